// File: rtl/mini_game_judge_if.sv
// Handshake between the question generator / button front end and the answer judge.
interface mini_game_judge_if;
   logic       valid;
   logic       is_correct;
   logic       btn_true;
   logic       btn_false;
   logic       restart;
   logic [7:0] score;
   logic [7:0] streak;
   logic [2:0] lives;
   logic       waiting;
   logic       result_ok;
   logic       result_bad;
   logic       game_over;

   modport master (
      output valid, is_correct, btn_true, btn_false, restart,
      input  score, streak, lives, waiting, result_ok, result_bad, game_over
   );

   modport slave (
      input  valid, is_correct, btn_true, btn_false, restart,
      output score, streak, lives, waiting, result_ok, result_bad, game_over
   );
endinterface

// File: rtl/mini_game_judge.sv
// BST mini game answer judge: checks TRUE/FALSE presses against is_correct and
// keeps score, streak and lives, with a timed result indication and game-over.
module mini_game_judge #(
   parameter int RESULT_HOLD    = 50_000_000,
   parameter int ANSWER_TIMEOUT = 250_000_000,
   parameter int MAX_LIVES      = 3
) (
   input logic              clk,
   input logic              rst_n,
   mini_game_judge_if.slave bus
);

   localparam int TMAX = (RESULT_HOLD > ANSWER_TIMEOUT) ? RESULT_HOLD : ANSWER_TIMEOUT;
   localparam int TW   = $clog2(TMAX);
   localparam logic [TW-1:0] AT_LAST = TW'(ANSWER_TIMEOUT - 1);
   localparam logic [TW-1:0] RH_LAST = TW'(RESULT_HOLD - 1);
   localparam logic [2:0]    LIVES0  = 3'(MAX_LIVES);

   typedef enum logic [1:0] {IDLE, WAIT, RESULT, OVER} state_t;

   state_t     state, state_n;
   logic [TW-1:0] timer, timer_d;
   logic [7:0] score_q, score_d, streak_q, streak_d;
   logic [2:0] lives_q, lives_d;
   logic       waiting_q, waiting_d, ok_q, ok_d, bad_q, bad_d, over_q, over_d;

   // Edge pulses are registered, so each FSM decision lands one cycle after the
   // input rise is sampled; bit order is {valid, btn_true, btn_false, restart}.
   logic [3:0] in_now, in_q, rise;
   assign in_now = {bus.valid, bus.btn_true, bus.btn_false, bus.restart};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_q <= '0;
         rise <= '0;
      end else begin
         in_q <= in_now;
         rise <= in_now & ~in_q;
      end
   end

   logic rise_v, rise_t, rise_f, rise_r, answered, correct;
   assign rise_v   = rise[3];
   assign rise_t   = rise[2];
   assign rise_f   = rise[1];
   assign rise_r   = rise[0];
   assign answered = rise_t | rise_f;
   // Both buttons at once is never correct.
   assign correct  = (rise_t ^ rise_f) & (rise_t ? bus.is_correct : ~bus.is_correct);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         timer     <= '0;
         score_q   <= '0;
         streak_q  <= '0;
         lives_q   <= LIVES0;
         waiting_q <= 1'b0;
         ok_q      <= 1'b0;
         bad_q     <= 1'b0;
         over_q    <= 1'b0;
      end else begin
         state     <= state_n;
         timer     <= timer_d;
         score_q   <= score_d;
         streak_q  <= streak_d;
         lives_q   <= lives_d;
         waiting_q <= waiting_d;
         ok_q      <= ok_d;
         bad_q     <= bad_d;
         over_q    <= over_d;
      end
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:   if (rise_v) state_n = WAIT;
         WAIT: begin
            if (!bus.valid)                     state_n = IDLE;
            else if (answered || timer == AT_LAST) state_n = RESULT;
         end
         RESULT: if (timer == RH_LAST) state_n = (lives_q == 3'd0) ? OVER : IDLE;
         OVER:   if (rise_r) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      timer_d  = timer;
      score_d  = score_q;
      streak_d = streak_q;
      lives_d  = lives_q;
      ok_d     = ok_q;
      bad_d    = bad_q;
      if (state_n != state)                   timer_d = '0;
      else if (state == WAIT || state == RESULT) timer_d = timer + 1'b1;

      if (state == WAIT && state_n == RESULT) begin
         if (answered && correct) begin
            score_d  = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
            streak_d = (streak_q == 8'hFF) ? streak_q : streak_q + 8'd1;
            ok_d     = 1'b1;
         end else begin
            lives_d  = (lives_q == 3'd0) ? lives_q : lives_q - 3'd1;
            streak_d = '0;
            bad_d    = 1'b1;
         end
      end
      if (state == RESULT && state_n != RESULT) begin
         ok_d  = 1'b0;
         bad_d = 1'b0;
      end
      if (state == OVER && state_n == IDLE) begin
         score_d  = '0;
         streak_d = '0;
         lives_d  = LIVES0;
      end
      waiting_d = (state_n == WAIT);
      over_d    = (state_n == OVER);
   end

   assign bus.score      = score_q;
   assign bus.streak     = streak_q;
   assign bus.lives      = lives_q;
   assign bus.waiting    = waiting_q;
   assign bus.result_ok  = ok_q;
   assign bus.result_bad = bad_q;
   assign bus.game_over  = over_q;

endmodule
